// File: rtl/dma_arbiter.sv
// Round-robin DMA arbiter for the weight reader, the feature-map reader and the result writer.
// It issues strided block reads or single-word writes. Every output is driven from a register.
module dma_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]              req_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [2:0]              gnt,
    output logic [2:0]              done,
    output logic                    beat_valid,
    output logic [3:0]              beat_idx,
    output logic                    dma_enable,
    output logic                    dma_rw,
    output logic [ADDR_WIDTH-1:0]   dma_address,
    output logic [DATA_WIDTH-1:0]   dma_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        LAST  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BLOCK_SIZE);

    state_t          state;
    logic [1:0]      last;
    logic [1:0]      owner;
    logic [3:0]      beats_left;
    logic [3:0]      beat_cnt;

    logic [1:0]            c0, c1, c2;
    logic [1:0]            pick;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [3:0]            len_sel;
    logic [3:0]            len_eff;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
    endfunction

    // Address stepping wraps naturally at 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        next_addr = a + STRIDE;
    endfunction

    // Pick the first request at or after the requester following the last winner.
    always_comb begin
        c0   = rr_next(last);
        c1   = rr_next(c0);
        c2   = rr_next(c1);
        pick = c2;
        if (req[c1]) pick = c1;
        if (req[c0]) pick = c0;
    end

    always_comb begin
        addr_sel = req_addr[0 +: ADDR_WIDTH];
        len_sel  = req_len[3:0];
        case (pick)
            2'd1: begin
                addr_sel = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
                len_sel  = req_len[7:4];
            end
            2'd2: addr_sel = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
            default: ;
        endcase
        len_eff = (len_sel == 4'd0) ? 4'd1 : len_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 2'd2;
            owner       <= 2'd0;
            beats_left  <= 4'd0;
            beat_cnt    <= 4'd0;
            gnt         <= 3'b000;
            done        <= 3'b000;
            beat_valid  <= 1'b0;
            beat_idx    <= 4'd0;
            dma_enable  <= 1'b0;
            dma_rw      <= 1'b1;
            dma_address <= '0;
            dma_wdata   <= '0;
        end else begin
            // Read data returns one cycle after the beat is issued.
            beat_valid <= dma_enable & dma_rw;
            beat_idx   <= beat_cnt;
            done       <= 3'b000;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner       <= pick;
                        gnt         <= onehot(pick);
                        dma_address <= addr_sel;
                        dma_enable  <= 1'b1;
                        beat_cnt    <= 4'd0;
                        if (pick == 2'd2) begin
                            state     <= WRITE;
                            dma_rw    <= 1'b0;
                            dma_wdata <= wr_data;
                        end else begin
                            state      <= READ;
                            dma_rw     <= 1'b1;
                            beats_left <= len_eff - 4'd1;
                        end
                    end
                end
                READ: begin
                    if (beats_left == 4'd0) begin
                        state      <= LAST;
                        dma_enable <= 1'b0;
                        done       <= gnt;
                    end else begin
                        beats_left  <= beats_left - 4'd1;
                        beat_cnt    <= beat_cnt + 4'd1;
                        dma_address <= next_addr(dma_address);
                    end
                end
                WRITE: begin
                    state      <= LAST;
                    dma_enable <= 1'b0;
                    dma_rw     <= 1'b1;
                    done       <= gnt;
                end
                LAST: begin
                    last  <= owner;
                    gnt   <= 3'b000;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: reset, reads, write, round-robin, address wrap, mid-burst reset.
module tb_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [47:0] req_addr;
    logic [7:0]  req_len;
    logic [15:0] wr_data;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        beat_valid;
    logic [3:0]  beat_idx;
    logic        dma_enable;
    logic        dma_rw;
    logic [15:0] dma_address;
    logic [15:0] dma_wdata;

    int errors = 0;
    int checks = 0;

    dma_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .BLOCK_SIZE(25)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .gnt(gnt), .done(done), .beat_valid(beat_valid),
        .beat_idx(beat_idx), .dma_enable(dma_enable), .dma_rw(dma_rw),
        .dma_address(dma_address), .dma_wdata(dma_wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [44:0] got;
        rst = 1'b1; req = 3'b000; req_addr = '0; req_len = 8'h00; wr_data = 16'h0;
        step(); step();
        got = {gnt, done, beat_valid, beat_idx, dma_enable, dma_rw, dma_address, dma_wdata};
        checks++;
        if (got !== {3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values: got %h, expected %h", got,
                     {3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 16'h0000});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        req = 3'b001; req_addr[15:0] = 16'h0000; req_len[3:0] = 4'd1;
        step();
        req = 3'b000;
        checks++;
        if ({gnt, dma_enable, dma_rw, dma_address} !== {3'b001, 1'b1, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL single_read_c1: got %h, expected %h",
                     {gnt, dma_enable, dma_rw, dma_address}, {3'b001, 1'b1, 1'b1, 16'h0000});
        end
        step();
        checks++;
        if ({gnt, done, beat_valid, beat_idx, dma_enable} !== {3'b001, 3'b001, 1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_read_c2: got %h, expected %h",
                     {gnt, done, beat_valid, beat_idx, dma_enable}, {3'b001, 3'b001, 1'b1, 4'd0, 1'b0});
        end
        step();
        checks++;
        if ({gnt, done, beat_valid} !== {3'b000, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL single_read_c3: got %h, expected %h", {gnt, done, beat_valid}, 7'h00);
        end
    endtask

    task automatic test_burst_read();
        logic [15:0] exp_addr [1:3] = '{16'd100, 16'd125, 16'd150};
        logic [2:0]  exp_gnt, exp_done;
        logic        exp_en, exp_bv;
        logic [3:0]  exp_idx;
        req = 3'b010; req_addr[31:16] = 16'd100; req_len[7:4] = 4'd3;
        for (int c = 1; c <= 5; c++) begin
            step();
            // Later input changes must not disturb the latched burst.
            req = 3'b000; req_addr[31:16] = 16'd999; req_len[7:4] = 4'd9;
            exp_gnt  = (c <= 4) ? 3'b010 : 3'b000;
            exp_done = (c == 4) ? 3'b010 : 3'b000;
            exp_en   = (c <= 3);
            exp_bv   = (c >= 2) && (c <= 4);
            exp_idx  = 4'(c - 2);
            checks++;
            if ({gnt, done, dma_enable, beat_valid} !== {exp_gnt, exp_done, exp_en, exp_bv}) begin
                errors++;
                $display("FAIL burst_ctrl_c%0d: got %h, expected %h", c,
                         {gnt, done, dma_enable, beat_valid}, {exp_gnt, exp_done, exp_en, exp_bv});
            end
            if (exp_en) begin
                checks++;
                if ({dma_rw, dma_address} !== {1'b1, exp_addr[c]}) begin
                    errors++;
                    $display("FAIL burst_addr_c%0d: got %h, expected %h", c,
                             {dma_rw, dma_address}, {1'b1, exp_addr[c]});
                end
            end
            if (exp_bv) begin
                checks++;
                if (beat_idx !== exp_idx) begin
                    errors++;
                    $display("FAIL burst_idx_c%0d: got %0d, expected %0d", c, beat_idx, exp_idx);
                end
            end
        end
    endtask

    task automatic test_write();
        req = 3'b100; req_addr[47:32] = 16'd7; wr_data = 16'h0400;
        step();
        req = 3'b000; wr_data = 16'hFFFF;
        checks++;
        if ({gnt, dma_enable, dma_rw, dma_address, dma_wdata} !== {3'b100, 1'b1, 1'b0, 16'd7, 16'h0400}) begin
            errors++;
            $display("FAIL write_c1: got %h, expected %h",
                     {gnt, dma_enable, dma_rw, dma_address, dma_wdata}, {3'b100, 1'b1, 1'b0, 16'd7, 16'h0400});
        end
        step();
        checks++;
        if ({gnt, done, beat_valid, dma_enable} !== {3'b100, 3'b100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_c2: got %h, expected %h",
                     {gnt, done, beat_valid, dma_enable}, {3'b100, 3'b100, 1'b0, 1'b0});
        end
        step();
        checks++;
        if ({gnt, done, beat_valid} !== 7'h00) begin
            errors++;
            $display("FAIL write_c3: got %h, expected %h", {gnt, done, beat_valid}, 7'h00);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rr [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] grants [4] = '{3'b000, 3'b000, 3'b000, 3'b000};
        logic [2:0] prev;
        int ngr = 0;
        bit adjacent = 1'b0;
        req = 3'b111; req_len = 8'h00; req_addr = {16'h0300, 16'h0200, 16'h0100};
        prev = gnt;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            step();
            if (gnt != 3'b000 && prev == 3'b000) begin
                grants[ngr] = gnt;
                ngr++;
            end
            if (gnt != 3'b000 && prev != 3'b000 && gnt != prev) adjacent = 1'b1;
            prev = gnt;
        end
        req = 3'b000;
        checks++;
        if (ngr !== 4) begin
            errors++;
            $display("FAIL rr_grant_count: got %0d, expected 4", ngr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grants[i] !== exp_rr[i]) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b, expected %b", i, grants[i], exp_rr[i]);
            end
        end
        checks++;
        if (adjacent !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_gap: got back-to-back grants, expected idle cycle between");
        end
        for (int c = 0; c < 10 && gnt != 3'b000; c++) step();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL rr_drain: got gnt %b, expected 000", gnt);
        end
    endtask

    task automatic test_wrap();
        req = 3'b001; req_addr[15:0] = 16'hFFF0; req_len[3:0] = 4'd2;
        step();
        req = 3'b000;
        checks++;
        if ({gnt, dma_enable, dma_address} !== {3'b001, 1'b1, 16'hFFF0}) begin
            errors++;
            $display("FAIL wrap_c1: got %h, expected %h", {gnt, dma_enable, dma_address}, {3'b001, 1'b1, 16'hFFF0});
        end
        step();
        checks++;
        if ({dma_enable, dma_address} !== {1'b1, 16'h0009}) begin
            errors++;
            $display("FAIL wrap_c2: got %h, expected %h", {dma_enable, dma_address}, {1'b1, 16'h0009});
        end
        step();
        checks++;
        if ({done, beat_valid, beat_idx} !== {3'b001, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL wrap_c3: got %h, expected %h", {done, beat_valid, beat_idx}, {3'b001, 1'b1, 4'd1});
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [44:0] got;
        bit stray = 1'b0;
        req = 3'b001; req_addr[15:0] = 16'h0200; req_len[3:0] = 4'd4;
        step();
        req = 3'b000;
        step();
        checks++;
        if ({dma_enable, dma_address} !== {1'b1, 16'h0219}) begin
            errors++;
            $display("FAIL rstmid_beat1: got %h, expected %h", {dma_enable, dma_address}, {1'b1, 16'h0219});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {gnt, done, beat_valid, beat_idx, dma_enable, dma_rw, dma_address, dma_wdata};
        checks++;
        if (got !== {3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL rstmid_values: got %h, expected %h", got,
                     {3'b000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 16'h0000});
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (done != 3'b000 || dma_enable != 1'b0 || gnt != 3'b000) stray = 1'b1;
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: got activity after reset, expected none");
        end
        // Requester 0 must have first priority again, even with requester 1 also asking.
        req = 3'b011; req_addr[15:0] = 16'h0040; req_len = 8'h11;
        step();
        req = 3'b000;
        checks++;
        if ({gnt, dma_enable, dma_address} !== {3'b001, 1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL rstmid_regrant: got %h, expected %h", {gnt, dma_enable, dma_address}, {3'b001, 1'b1, 16'h0040});
        end
        step();
        checks++;
        if (done !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_done: got %b, expected 001", done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_burst_read();
        test_write();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
